div_ctrl8: RTL and testbench

Sequential 8-bit unsigned divider that runs the non-restoring shift/add-subtract recurrence one quotient bit per clock and drives the result to the ALU result mux. It sits directly downstream of the per-bit division stage logic. It owns:
- the iteration counter;
- the partial-remainder and quotient registers;
- the final remainder-correction step;
- the start/busy/done handshake.

A 9-bit partial remainder makes the full 8-bit operand range correct.

---
 rtl/div_ctrl8.sv | 123 ++++++++++++
 tb/tb_div_ctrl8.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl8.sv
// Sequential 8-bit unsigned non-restoring divider: one quotient bit per clock,
// final remainder correction, and a start/busy/done handshake.
module div_ctrl8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [7:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [7:0] remainder,
    output logic       dz
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] a_q, a_d;
    logic [7:0] q_q, q_d;
    logic [7:0] m_q, m_d;
    logic [2:0] cnt_q, cnt_d;
    logic       zflag_q, zflag_d;
    logic [7:0] quo_q, quo_d;
    logic [7:0] rem_q, rem_d;
    logic       dz_q, dz_d;
    logic       done_q, done_d;

    logic [8:0] shifted;
    logic [8:0] fixed_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            cnt_q   <= '0;
            zflag_q <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            zflag_q <= zflag_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        zflag_d = zflag_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        // S can overflow 9 bits, but the new A always fits, so modulo-2^9 is exact.
        shifted = {a_q[7:0], q_q[7]};
        fixed_a = a_q + {1'b0, m_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d   = '0;
                    q_d   = dividend;
                    m_d   = divisor;
                    cnt_d = '0;
                    if (divisor == 8'd0) begin
                        zflag_d = 1'b1;
                        state_d = FIX;
                    end else begin
                        zflag_d = 1'b0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_d   = a_q[8] ? (shifted + {1'b0, m_q}) : (shifted - {1'b0, m_q});
                q_d   = {q_q[6:0], ~a_d[8]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'd7) state_d = FIX;
            end
            FIX: begin
                if (zflag_q) begin
                    quo_d = 8'hFF;
                    rem_d = q_q;
                    dz_d  = 1'b1;
                end else begin
                    quo_d = q_q;
                    rem_d = a_q[8] ? fixed_a[7:0] : a_q[7:0];
                    dz_d  = 1'b0;
                end
                zflag_d = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dz        = dz_q;

endmodule

// File: tb/tb_div_ctrl8.sv
// Self-checking bench for div_ctrl8: directed and random divisions compared
// against plain / and % arithmetic, plus handshake, reset and throughput checks.
`timescale 1ns/1ps
module tb_div_ctrl8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend, divisor;
    logic       busy, done, dz;
    logic [7:0] quotient, remainder;

    int checks = 0;
    int errors = 0;

    div_ctrl8 dut (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dz(dz)
    );

    always #5 clk = ~clk;

    // Reference: integer division; divide-by-zero returns all-ones and the dividend.
    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] eq, output logic [7:0] er,
                         output logic ez, output int elat);
        if (b == 8'd0) begin
            eq = 8'hFF; er = a; ez = 1'b1; elat = 1;
        end else begin
            eq = 8'(int'(a) / int'(b)); er = 8'(int'(a) % int'(b)); ez = 1'b0; elat = 9;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; optionally pulse start with junk operands while busy.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit noise);
        logic [7:0] eq, er;
        logic       ez;
        int         elat, lat, dones;
        model(a, b, eq, er, ez, elat);
        start = 1'b1; dividend = a; divisor = b;
        tick();
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL accept_busy %0d/%0d: busy=%b want 1", a, b, busy);
        end
        lat = 0; dones = 0;
        while (done !== 1'b1 && lat < 20) begin
            start = noise && (lat == 2 || lat == 4);
            if (start) begin dividend = $urandom; divisor = $urandom_range(1, 255); end
            tick();
            lat++;
            start = 1'b0;
            if (done !== 1'b1 && busy !== 1'b1) begin
                checks++; errors++;
                $display("FAIL busy_drop %0d/%0d: busy=0 at cycle %0d", a, b, lat);
            end
        end
        checks++;
        if (lat !== elat) begin
            errors++; $display("FAIL latency %0d/%0d: got %0d want %0d", a, b, lat, elat);
        end
        checks++;
        if (quotient !== eq || remainder !== er || dz !== ez || busy !== 1'b0) begin
            errors++;
            $display("FAIL result %0d/%0d: got q=%0d r=%0d dz=%b busy=%b want q=%0d r=%0d dz=%b busy=0",
                     a, b, quotient, remainder, dz, busy, eq, er, ez);
        end
        // No further done pulse and the result holds.
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || quotient !== eq || remainder !== er || dz !== ez) begin
            errors++;
            $display("FAIL hold %0d/%0d: extra_done=%0d q=%0d r=%0d dz=%b want q=%0d r=%0d dz=%b",
                     a, b, dones, quotient, remainder, dz, eq, er, ez);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        checks++;
        if ({busy, done, dz, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b dz=%b q=%0d r=%0d want all 0",
                     busy, done, dz, quotient, remainder);
        end
        @(negedge clk); rst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_op(8'd200, 8'd7,   1'b0);
        run_op(8'd255, 8'd128, 1'b0);
        run_op(8'd255, 8'd1,   1'b0);
        run_op(8'd255, 8'd255, 1'b0);
        run_op(8'd5,   8'd9,   1'b0);
        run_op(8'd0,   8'd3,   1'b0);
    endtask

    task automatic test_div_zero();
        run_op(8'd77, 8'd0, 1'b0);
        run_op(8'd10, 8'd3, 1'b0);
    endtask

    task automatic test_ignored_start();
        run_op(8'd123, 8'd10, 1'b1);
    endtask

    task automatic test_mid_reset();
        int seen = 0;
        start = 1'b1; dividend = 8'd200; divisor = 8'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, dz, quotient, remainder} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b dz=%b q=%0d r=%0d want all 0",
                     busy, done, dz, quotient, remainder);
        end
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL aborted_op: done/busy seen %0d cycles want 0", seen);
        end
        run_op(8'd100, 8'd9, 1'b0);
    endtask

    // start held high: each done cycle is also the next accept cycle.
    task automatic test_back_to_back();
        logic [7:0] hq, hr;
        int last = -1, pulses = 0, guard = 0;
        run_op(8'd7, 8'd2, 1'b0);
        hq = quotient; hr = remainder;
        start = 1'b1; dividend = 8'd100; divisor = 8'd9;
        for (int cyc = 0; cyc < 45; cyc++) begin
            tick();
            if (done === 1'b1) begin
                pulses++;
                checks++;
                if (quotient !== 8'd11 || remainder !== 8'd1 || dz !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_result: got q=%0d r=%0d dz=%b want 11/1/0", quotient, remainder, dz);
                end
                checks++;
                if ((last < 0 && cyc != 9) || (last >= 0 && cyc - last != 10)) begin
                    errors++;
                    $display("FAIL b2b_spacing: done at cycle %0d prev %0d want first 9 then every 10", cyc, last);
                end
                last = cyc; hq = quotient; hr = remainder;
            end else if (quotient !== hq || remainder !== hr) begin
                checks++; errors++;
                $display("FAIL b2b_glitch: cycle %0d q=%0d r=%0d want %0d/%0d", cyc, quotient, remainder, hq, hr);
            end
        end
        start = 1'b0;
        checks++;
        if (pulses != 4) begin
            errors++; $display("FAIL b2b_count: got %0d pulses want 4", pulses);
        end
        while (busy === 1'b1 && guard < 20) begin tick(); guard++; end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_op(a, b, ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_ignored_start();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
